// File: rtl/eth_pkg.sv
// Shared constants, state encoding and FCS helpers for the Ethernet receive
// FCS checker.
package eth_pkg;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
    localparam int          CNT_W    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        CHECK = 2'd3
    } rx_state_e;

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        return {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
    endfunction

    // Expected FCS in arrival order: first-received byte in the top lane.
    function automatic logic [31:0] fcs_expect(input logic [31:0] crc);
        return {~bitrev8(crc[31:24]), ~bitrev8(crc[23:16]),
                ~bitrev8(crc[15:8]),  ~bitrev8(crc[7:0])};
    endfunction
endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational byte-wide CRC-32 next-state function. Byte LSB enters the
// MSB-first engine first, i.e. the byte is fed bit-reversed.
module eth_crc32_d8 import eth_pkg::*; (
    input  logic [7:0]  data_i,
    input  logic [31:0] crc_i,
    output logic [31:0] crc_o
);
    logic [31:0] c;
    logic [7:0]  d;
    logic        fb;

    always_comb begin
        c  = crc_i;
        d  = data_i;
        fb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ d[0];
            c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
            d  = d >> 1;
        end
        crc_o = c;
    end
endmodule

// File: rtl/eth_rx_fcs_check.sv
// Receive-side FCS checker: strips the 4 trailing FCS bytes through a delay
// line, checks them against the running CRC and reports per-frame status.
module eth_rx_fcs_check import eth_pkg::*; (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_sof,
    input  logic             in_eof,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_sof,
    output logic             out_eof,
    output logic             stat_valid,
    output logic             stat_fcs_ok,
    output logic             stat_runt,
    output logic             stat_abort,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);
    rx_state_e        state_q, state_d;
    logic [31:0]      crc_q, crc_d, crc_next;
    logic [3:0][7:0]  dl_q, dl_d;
    logic [2:0]       fill_q, fill_d;
    logic             first_q, first_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_sof_q, out_sof_d;
    logic             out_eof_q, out_eof_d;
    logic             stat_valid_q, stat_valid_d;
    logic             stat_ok_q, stat_ok_d;
    logic             stat_runt_q, stat_runt_d;
    logic             stat_abort_q, stat_abort_d;
    logic [CNT_W-1:0] good_q, good_d;
    logic [CNT_W-1:0] bad_q, bad_d;
    logic             start;
    logic             fcs_match;

    // dl_q[3] is the oldest byte; it is the one released to the CRC and output.
    eth_crc32_d8 u_crc (
        .data_i (dl_q[3]),
        .crc_i  (crc_q),
        .crc_o  (crc_next)
    );

    assign fcs_match = (dl_q == fcs_expect(crc_q));

    always_comb begin
        state_d      = state_q;
        crc_d        = crc_q;
        dl_d         = dl_q;
        fill_d       = fill_q;
        first_d      = first_q;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        out_sof_d    = 1'b0;
        out_eof_d    = 1'b0;
        stat_valid_d = 1'b0;
        stat_ok_d    = 1'b0;
        stat_runt_d  = 1'b0;
        stat_abort_d = 1'b0;
        good_d       = good_q;
        bad_d        = bad_q;
        start        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_sof) begin
                    if (in_eof) begin
                        stat_valid_d = 1'b1;
                        stat_runt_d  = 1'b1;
                    end else begin
                        start = 1'b1;
                    end
                end
            end
            FILL, RUN: begin
                if (in_valid) begin
                    if (in_sof) begin
                        // New frame preempts the old one; a sof+eof byte is itself too short.
                        stat_valid_d = 1'b1;
                        stat_abort_d = 1'b1;
                        if (in_eof) state_d = IDLE;
                        else        start   = 1'b1;
                    end else if (state_q == FILL) begin
                        if (in_eof) begin
                            stat_valid_d = 1'b1;
                            stat_runt_d  = 1'b1;
                            state_d      = IDLE;
                        end else begin
                            dl_d   = {dl_q[2:0], in_data};
                            fill_d = fill_q + 3'd1;
                            if (fill_q == 3'd3) state_d = RUN;
                        end
                    end else begin
                        dl_d        = {dl_q[2:0], in_data};
                        crc_d       = crc_next;
                        out_valid_d = 1'b1;
                        out_data_d  = dl_q[3];
                        out_sof_d   = first_q;
                        first_d     = 1'b0;
                        if (in_eof) begin
                            out_eof_d = 1'b1;
                            state_d   = CHECK;
                        end
                    end
                end
            end
            CHECK: begin
                stat_valid_d = 1'b1;
                stat_ok_d    = fcs_match;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            dl_d    = {24'h0, in_data};
            crc_d   = CRC_INIT;
            fill_d  = 3'd1;
            first_d = 1'b1;
            state_d = FILL;
        end

        if (stat_valid_d) begin
            if (stat_ok_d) begin
                if (good_q != '1) good_d = good_q + 1'b1;
            end else begin
                if (bad_q != '1) bad_d = bad_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            crc_q        <= CRC_INIT;
            dl_q         <= '0;
            fill_q       <= '0;
            first_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sof_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            stat_valid_q <= 1'b0;
            stat_ok_q    <= 1'b0;
            stat_runt_q  <= 1'b0;
            stat_abort_q <= 1'b0;
            good_q       <= '0;
            bad_q        <= '0;
        end else begin
            state_q      <= state_d;
            crc_q        <= crc_d;
            dl_q         <= dl_d;
            fill_q       <= fill_d;
            first_q      <= first_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sof_q    <= out_sof_d;
            out_eof_q    <= out_eof_d;
            stat_valid_q <= stat_valid_d;
            stat_ok_q    <= stat_ok_d;
            stat_runt_q  <= stat_runt_d;
            stat_abort_q <= stat_abort_d;
            good_q       <= good_d;
            bad_q        <= bad_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_sof     = out_sof_q;
    assign out_eof     = out_eof_q;
    assign stat_valid  = stat_valid_q;
    assign stat_fcs_ok = stat_ok_q;
    assign stat_runt   = stat_runt_q;
    assign stat_abort  = stat_abort_q;
    assign good_cnt    = good_q;
    assign bad_cnt     = bad_q;
endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Bench for eth_rx_fcs_check: random frames against a reflected-CRC frame model.
module tb_eth_rx_fcs_check;
    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0;
    logic [7:0]  in_data = 8'h0;
    logic        out_valid, out_sof, out_eof;
    logic [7:0]  out_data;
    logic        stat_valid, stat_fcs_ok, stat_runt, stat_abort;
    logic [15:0] good_cnt, bad_cnt;

    eth_rx_fcs_check dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_sof(in_sof), .in_eof(in_eof), .out_valid(out_valid),
        .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
        .stat_valid(stat_valid), .stat_fcs_ok(stat_fcs_ok),
        .stat_runt(stat_runt), .stat_abort(stat_abort),
        .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    always #5 clk = ~clk;

    int chk_cnt = 0, pass_cnt = 0;
    int cyc = 0, eof_cyc = -10, stat_cyc = -10;
    int good_m = 0, bad_m = 0;
    logic [7:0] frm[$];
    logic [9:0] mon_d[$], exp_d[$];   // {sof, eof, data}
    logic [2:0] mon_s[$], exp_s[$];   // {fcs_ok, runt, abort}

    initial forever begin
        @(negedge clk);
        cyc++;
        if (out_valid === 1'b1) begin
            mon_d.push_back({out_sof, out_eof, out_data});
            if (out_eof === 1'b1) eof_cyc = cyc;
        end
        if (stat_valid === 1'b1) begin
            mon_s.push_back({stat_fcs_ok, stat_runt, stat_abort});
            stat_cyc = cyc;
        end
    end

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // Standard reflected CRC-32 of frm[0..n-1], final value inverted.
    function automatic logic [31:0] ref_crc(input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, frm[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic int d_diff(output logic [9:0] got, output logic [9:0] want);
        int n;
        n = (mon_d.size() > exp_d.size()) ? mon_d.size() : exp_d.size();
        got = 'x; want = 'x;
        for (int i = 0; i < n; i++) begin
            got  = (i < mon_d.size()) ? mon_d[i] : 10'bx;
            want = (i < exp_d.size()) ? exp_d[i] : 10'bx;
            if (got !== want) return i;
        end
        return -1;
    endfunction

    function automatic int s_diff(output logic [2:0] got, output logic [2:0] want);
        int n;
        n = (mon_s.size() > exp_s.size()) ? mon_s.size() : exp_s.size();
        got = 'x; want = 'x;
        for (int i = 0; i < n; i++) begin
            got  = (i < mon_s.size()) ? mon_s[i] : 3'bx;
            want = (i < exp_s.size()) ? exp_s[i] : 3'bx;
            if (got !== want) return i;
        end
        return -1;
    endfunction

    task automatic model_frame();
        int n; logic [31:0] c; logic ok;
        n = frm.size();
        if (n < 5) begin
            exp_s.push_back(3'b010);
            bad_m = sat(bad_m + 1);
        end else begin
            for (int i = 0; i < n - 4; i++) exp_d.push_back({i == 0, i == n - 5, frm[i]});
            c  = ref_crc(n - 4);
            ok = ({frm[n-1], frm[n-2], frm[n-3], frm[n-4]} == c);
            exp_s.push_back({ok, 2'b00});
            if (ok) good_m = sat(good_m + 1);
            else    bad_m  = sat(bad_m + 1);
        end
    endtask

    task automatic model_abort();
        for (int i = 0; i < frm.size() - 4; i++) exp_d.push_back({i == 0, 1'b0, frm[i]});
        exp_s.push_back(3'b001);
        bad_m = sat(bad_m + 1);
    endtask

    task automatic build_raw(input int n);
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic build_good(input int n);
        logic [31:0] c;
        build_raw(n);
        c = ref_crc(n);
        frm.push_back(c[7:0]); frm.push_back(c[15:8]);
        frm.push_back(c[23:16]); frm.push_back(c[31:24]);
    endtask

    task automatic corrupt();
        int idx;
        idx = $urandom_range(0, frm.size() - 1);
        frm[idx] = frm[idx] ^ (8'h1 << $urandom_range(0, 7));
    endtask

    task automatic clear();
        mon_d.delete(); exp_d.delete(); mon_s.delete(); exp_s.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive(input logic [7:0] b, input logic s, input logic e);
        in_valid = 1'b1; in_data = b; in_sof = s; in_eof = e;
        @(posedge clk); #1;
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_data = 8'($urandom);
    endtask

    task automatic send_frm(input int gap_max, input logic with_eof);
        for (int i = 0; i < frm.size(); i++) begin
            if (gap_max > 0) idle($urandom_range(0, gap_max));
            drive(frm[i], i == 0, with_eof && (i == frm.size() - 1));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_cnt++;
        if ({out_valid, out_sof, out_eof, stat_valid, stat_fcs_ok, stat_runt, stat_abort} !== 7'b0)
            $display("FAIL reset_strobes: got %b want 0000000",
                     {out_valid, out_sof, out_eof, stat_valid, stat_fcs_ok, stat_runt, stat_abort});
        else pass_cnt++;
        chk_cnt++;
        if (out_data !== 8'h00) $display("FAIL reset_out_data: got %h want 00", out_data);
        else pass_cnt++;
        chk_cnt++;
        if ({good_cnt, bad_cnt} !== 32'h0) $display("FAIL reset_counters: got %h/%h want 0/0", good_cnt, bad_cnt);
        else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(8'h55, 1'b0, 1'b0);      // stray byte in IDLE without sof
        idle(3);
        chk_cnt++;
        if (mon_d.size() + mon_s.size() != 0)
            $display("FAIL idle_ignore: got %0d events want 0", mon_d.size() + mon_s.size());
        else pass_cnt++;
    endtask

    task automatic test_known(input logic bad);
        int k; logic [9:0] g, w; logic [2:0] gs, ws; logic [19:0] ends;
        clear();
        frm.delete();
        for (int i = 0; i < 9; i++) frm.push_back(8'h31 + 8'(i));
        frm.push_back(8'h26); frm.push_back(8'h39); frm.push_back(8'hF4);
        frm.push_back(bad ? 8'hCA : 8'hCB);
        model_frame();
        send_frm(0, 1'b1);
        idle(4);
        k = d_diff(g, w);
        chk_cnt++;
        if (k != -1) $display("FAIL known_payload: idx %0d got %h want %h", k, g, w);
        else pass_cnt++;
        ends = (mon_d.size() == 9) ? {mon_d[0], mon_d[8]} : 20'bx;
        chk_cnt++;
        if (ends !== {10'h231, 10'h139}) $display("FAIL known_sof_eof: got %h want %h", ends, {10'h231, 10'h139});
        else pass_cnt++;
        gs = (mon_s.size() == 1) ? mon_s[0] : 3'bx;
        ws = bad ? 3'b000 : 3'b100;
        chk_cnt++;
        if (gs !== ws) $display("FAIL known_status: got %b want %b", gs, ws);
        else pass_cnt++;
        k = s_diff(gs, ws);
        chk_cnt++;
        if (k != -1) $display("FAIL known_model_status: idx %0d got %b want %b", k, gs, ws);
        else pass_cnt++;
        chk_cnt++;
        if (stat_cyc !== eof_cyc + 1) $display("FAIL known_stat_timing: got cycle %0d want %0d", stat_cyc, eof_cyc + 1);
        else pass_cnt++;
        chk_cnt++;
        if ({good_cnt, bad_cnt} !== {16'd1, bad ? 16'd1 : 16'd0})
            $display("FAIL known_counters: got %0d/%0d want 1/%0d", good_cnt, bad_cnt, bad ? 1 : 0);
        else pass_cnt++;
    endtask

    task automatic test_runt();
        int k; logic [9:0] g, w; logic [2:0] gs, ws;
        clear();
        build_raw(3);
        model_frame();
        send_frm(0, 1'b1);
        idle(3);
        chk_cnt++;
        if (mon_d.size() != 0 || mon_s.size() != 1 || mon_s[0] !== 3'b010)
            $display("FAIL runt3: got %0d bytes/%0d stats want 0 bytes, status 010", mon_d.size(), mon_s.size());
        else pass_cnt++;
        build_good(1);
        model_frame();
        send_frm(0, 1'b1);
        idle(3);
        g = (mon_d.size() == 1) ? mon_d[0] : 10'bx;
        chk_cnt++;
        if (g[9:8] !== 2'b11) $display("FAIL five_byte_sof_eof: got %b want 11", g[9:8]);
        else pass_cnt++;
        build_raw(4); model_frame(); send_frm(0, 1'b1); idle(2);
        build_raw(1); model_frame(); send_frm(0, 1'b1); idle(2);
        k = d_diff(g, w);
        chk_cnt++;
        if (k != -1) $display("FAIL runt_payload: idx %0d got %h want %h", k, g, w);
        else pass_cnt++;
        k = s_diff(gs, ws);
        chk_cnt++;
        if (k != -1) $display("FAIL runt_status: idx %0d got %b want %b", k, gs, ws);
        else pass_cnt++;
        chk_cnt++;
        if ({good_cnt, bad_cnt} !== {16'(good_m), 16'(bad_m)})
            $display("FAIL runt_counters: got %0d/%0d want %0d/%0d", good_cnt, bad_cnt, good_m, bad_m);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        int k; logic [9:0] g, w; logic [2:0] gs, ws;
        clear();
        build_raw(10);
        model_abort();
        send_frm(0, 1'b0);
        idle(2);
        build_good($urandom_range(1, 20));
        model_frame();
        send_frm(0, 1'b1);
        idle(4);
        gs = (mon_s.size() > 0) ? mon_s[0] : 3'bx;
        chk_cnt++;
        if (gs !== 3'b001) $display("FAIL abort_flag: got %b want 001", gs);
        else pass_cnt++;
        k = d_diff(g, w);
        chk_cnt++;
        if (k != -1) $display("FAIL abort_payload: idx %0d got %h want %h", k, g, w);
        else pass_cnt++;
        k = s_diff(gs, ws);
        chk_cnt++;
        if (k != -1) $display("FAIL abort_status: idx %0d got %b want %b", k, gs, ws);
        else pass_cnt++;
        chk_cnt++;
        if ({good_cnt, bad_cnt} !== {16'(good_m), 16'(bad_m)})
            $display("FAIL abort_counters: got %0d/%0d want %0d/%0d", good_cnt, bad_cnt, good_m, bad_m);
        else pass_cnt++;
    endtask

    task automatic test_gaps();
        int k; logic [9:0] g, w; logic [2:0] gs, ws;
        clear();
        build_good($urandom_range(5, 30));
        model_frame();
        send_frm(3, 1'b1);
        idle(4);
        k = d_diff(g, w);
        chk_cnt++;
        if (k != -1) $display("FAIL gaps_payload: idx %0d got %h want %h", k, g, w);
        else pass_cnt++;
        k = s_diff(gs, ws);
        chk_cnt++;
        if (k != -1 || mon_s.size() != 1 || mon_s[0] !== 3'b100)
            $display("FAIL gaps_status: idx %0d got %b want 100", k, gs);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int k; logic [9:0] g, w; logic [2:0] gs, ws;
        clear();
        for (int f = 0; f < 10; f++) begin
            if ($urandom_range(0, 2) == 0) drive(8'($urandom), 1'b0, 1'($urandom));
            if ($urandom_range(0, 4) == 0) build_raw($urandom_range(1, 4));
            else begin
                build_good($urandom_range(1, 32));
                if ($urandom_range(0, 1) == 1) corrupt();
            end
            model_frame();
            send_frm($urandom_range(0, 1), 1'b1);
            idle(1);
        end
        idle(4);
        k = d_diff(g, w);
        chk_cnt++;
        if (k != -1) $display("FAIL b2b_payload: idx %0d got %h want %h", k, g, w);
        else pass_cnt++;
        k = s_diff(gs, ws);
        chk_cnt++;
        if (k != -1) $display("FAIL b2b_status: idx %0d got %b want %b", k, gs, ws);
        else pass_cnt++;
        chk_cnt++;
        if ({good_cnt, bad_cnt} !== {16'(good_m), 16'(bad_m)})
            $display("FAIL b2b_counters: got %0d/%0d want %0d/%0d", good_cnt, bad_cnt, good_m, bad_m);
        else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        int k; logic [9:0] g, w;
        build_raw(8);
        send_frm(0, 1'b0);
        #2 rst = 1'b1;
        clear();
        good_m = 0; bad_m = 0;
        idle(2);
        rst = 1'b0;
        idle(6);
        chk_cnt++;
        if (mon_s.size() != 0 || mon_d.size() != 0)
            $display("FAIL rst_mid_quiet: got %0d stats/%0d bytes want 0/0", mon_s.size(), mon_d.size());
        else pass_cnt++;
        chk_cnt++;
        if ({good_cnt, bad_cnt} !== 32'h0) $display("FAIL rst_mid_counters: got %0d/%0d want 0/0", good_cnt, bad_cnt);
        else pass_cnt++;
        build_good(6);
        model_frame();
        send_frm(0, 1'b1);
        idle(4);
        k = d_diff(g, w);
        chk_cnt++;
        if (k != -1 || mon_s.size() != 1 || mon_s[0] !== 3'b100)
            $display("FAIL rst_mid_recover: idx %0d got %h want %h", k, g, w);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        logic [2:0] gs, ws; int k;
        clear();
        for (int i = 0; i < 65536; i++) drive(8'($urandom), 1'b1, 1'b1);
        bad_m = sat(bad_m + 65536);
        idle(3);
        chk_cnt++;
        if (bad_cnt !== 16'hFFFF) $display("FAIL sat_reach: got %h want ffff", bad_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (good_cnt !== 16'(good_m)) $display("FAIL sat_good_untouched: got %0d want %0d", good_cnt, good_m);
        else pass_cnt++;
        clear();
        build_good(8);
        corrupt();
        model_frame();
        send_frm(0, 1'b1);
        idle(4);
        k = s_diff(gs, ws);
        chk_cnt++;
        if (k != -1) $display("FAIL sat_status: idx %0d got %b want %b", k, gs, ws);
        else pass_cnt++;
        chk_cnt++;
        if (bad_cnt !== 16'(bad_m)) $display("FAIL sat_hold: got %h want %h", bad_cnt, 16'(bad_m));
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_known(1'b0);
        test_known(1'b1);
        test_runt();
        test_abort();
        test_gaps();
        test_back_to_back();
        test_reset_midframe();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
